// File: rtl/image_pkg.sv
// Shared definitions for the B-mode scan controller.
// Holds the host UART opcode bytes and the scan state encoding. The state
// encoding is also consumed by debug LEDs and the UART status reporter.
package image_pkg;

  // Host command opcodes (ASCII)
  localparam logic [7:0] CMD_START = 8'h53;  // 'S'
  localparam logic [7:0] CMD_ABORT = 8'h41;  // 'A'
  localparam logic [7:0] CMD_LEN   = 8'h4C;  // 'L', followed by one operand byte

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWaitAck,
    StWaitTx,
    StWaitClear,
    StHoldoff,
    StDone
  } scan_state_e;

endpackage

// File: rtl/scan_cmd_parser.sv
// Host command byte decoder for the scan controller.
// Turns the strobed UART byte stream into single-cycle requests so the scan
// FSM never sees the byte protocol.
//   clk, rst             : clock, asynchronous active-low reset
//   received_data_i      : command or operand byte
//   new_received_data_i  : one-cycle strobe qualifying received_data_i
//   start_req_o          : 'S' seen as an opcode
//   abort_req_o          : 'A' seen as an opcode
//   len_wr_o             : operand byte following 'L' has arrived
//   len_val_o            : clamped line count (1..MaxLines), valid with len_wr_o
module scan_cmd_parser #(
  parameter int unsigned MaxLines = 64,
  parameter int unsigned LenW     = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      received_data_i,
  input  logic            new_received_data_i,
  output logic            start_req_o,
  output logic            abort_req_o,
  output logic            len_wr_o,
  output logic [LenW-1:0] len_val_o
);
  import image_pkg::*;

  // High when the next strobed byte is the operand of 'L'
  logic opnd_q, opnd_d;

  always_comb begin
    opnd_d      = opnd_q;
    start_req_o = 1'b0;
    abort_req_o = 1'b0;
    len_wr_o    = 1'b0;

    // Zero and out-of-range counts both mean "full frame"
    len_val_o = LenW'(MaxLines);
    if (received_data_i != 8'd0 && 32'(received_data_i) <= MaxLines) begin
      len_val_o = LenW'(received_data_i);
    end

    if (new_received_data_i) begin
      if (opnd_q) begin
        // Operand is never reinterpreted as an opcode, even if it looks like one
        len_wr_o = 1'b1;
        opnd_d   = 1'b0;
      end else begin
        case (received_data_i)
          CMD_START: start_req_o = 1'b1;
          CMD_ABORT: abort_req_o = 1'b1;
          CMD_LEN:   opnd_d      = 1'b1;
          default:   ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opnd_q <= 1'b0;
    end else begin
      opnd_q <= opnd_d;
    end
  end

endmodule

// File: rtl/image_scan_controller.sv
// Frame sequencer for the B-mode transmit path.
// Walks image_transmit_fsm through num_lines scan lines: one start pulse per
// line, follow busy through transmit/receive, wait for the host to drain line
// memory (mem_clear), then hold off for the pulse-repetition limit.
//   clk, rst             : clock, asynchronous active-low reset
//   received_data_i      : host command byte
//   new_received_data_i  : strobe qualifying received_data_i
//   busy_i               : transmit FSM busy (transmit start .. capture done)
//   mem_clear_i          : one-cycle pulse, host drained line memory
//   start_transmit_o     : one-cycle start pulse to the transmit FSM
//   line_idx_o           : current scan line, 0-based
//   scanning_o           : registered, high whenever not idle
//   frame_done_o         : one-cycle pulse after the last line completes
//   timeout_err_o        : sticky watchdog flag, cleared by the next 'S'
module image_scan_controller #(
  parameter int unsigned MAX_LINES      = 64,
  parameter int unsigned LINE_W         = 6,
  parameter int unsigned DEFAULT_LINES  = 8,
  parameter int unsigned HOLDOFF_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        received_data_i,
  input  logic              new_received_data_i,
  input  logic              busy_i,
  input  logic              mem_clear_i,
  output logic              start_transmit_o,
  output logic [LINE_W-1:0] line_idx_o,
  output logic              scanning_o,
  output logic              frame_done_o,
  output logic              timeout_err_o
);
  import image_pkg::*;

  // Line count needs one extra bit to hold MAX_LINES itself
  localparam int unsigned LenW = LINE_W + 1;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + HOLDOFF_CYCLES + 1);

  logic            start_req, abort_req, len_wr;
  logic [LenW-1:0] len_val;

  scan_cmd_parser #(
    .MaxLines (MAX_LINES),
    .LenW     (LenW)
  ) u_parser (
    .clk                 (clk),
    .rst                 (rst),
    .received_data_i     (received_data_i),
    .new_received_data_i (new_received_data_i),
    .start_req_o         (start_req),
    .abort_req_o         (abort_req),
    .len_wr_o            (len_wr),
    .len_val_o           (len_val)
  );

  scan_state_e       state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [LINE_W-1:0] line_idx_q, line_idx_d;
  logic [LenW-1:0]   num_lines_q, num_lines_d;
  logic              clear_seen_q, clear_seen_d;
  logic              timeout_err_q, timeout_err_d;
  logic              scanning_q;
  logic              wd_expired, last_line;

  // Shared counter: watchdog in the wait states, holdoff timer in StHoldoff.
  // Reaching TIMEOUT_CYCLES-1 without leaving means the state has already been
  // occupied for TIMEOUT_CYCLES clocks.
  assign wd_expired = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign last_line  = ({1'b0, line_idx_q} == num_lines_q - LenW'(1));

  always_comb begin
    state_d       = state_q;
    line_idx_d    = line_idx_q;
    num_lines_d   = num_lines_q;
    clear_seen_d  = clear_seen_q;
    timeout_err_d = timeout_err_q;

    if (len_wr && state_q == StIdle) begin
      num_lines_d = len_val;
    end

    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          state_d       = StStart;
          line_idx_d    = '0;
          timeout_err_d = 1'b0;
        end
      end
      StStart: begin
        clear_seen_d = 1'b0;
        state_d      = StWaitAck;
      end
      StWaitAck: begin
        if (mem_clear_i) clear_seen_d = 1'b1;
        if (busy_i) begin
          state_d = StWaitTx;
        end else if (wd_expired) begin
          state_d       = StIdle;
          timeout_err_d = 1'b1;
        end
      end
      StWaitTx: begin
        if (mem_clear_i) clear_seen_d = 1'b1;
        if (!busy_i) begin
          state_d = StWaitClear;
        end else if (wd_expired) begin
          state_d       = StIdle;
          timeout_err_d = 1'b1;
        end
      end
      StWaitClear: begin
        if (mem_clear_i || clear_seen_q) begin
          state_d = last_line ? StDone : StHoldoff;
        end else if (wd_expired) begin
          state_d       = StIdle;
          timeout_err_d = 1'b1;
        end
      end
      StHoldoff: begin
        if (cnt_q == CntW'(HOLDOFF_CYCLES)) begin
          line_idx_d = line_idx_q + LINE_W'(1);
          state_d    = StStart;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort wins over any transition decided above
    if (abort_req) begin
      state_d    = StIdle;
      line_idx_d = '0;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q inside {StWaitAck, StWaitTx, StWaitClear, StHoldoff}) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      line_idx_q    <= '0;
      num_lines_q   <= LenW'(DEFAULT_LINES);
      clear_seen_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      scanning_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      line_idx_q    <= line_idx_d;
      num_lines_q   <= num_lines_d;
      clear_seen_q  <= clear_seen_d;
      timeout_err_q <= timeout_err_d;
      scanning_q    <= (state_d != StIdle);
    end
  end

  // StStart lasts one cycle and is always followed by StWaitAck or StIdle,
  // so the start pulse can never repeat on consecutive cycles.
  assign start_transmit_o = (state_q == StStart);
  assign frame_done_o     = (state_q == StDone);
  assign line_idx_o       = line_idx_q;
  assign scanning_o       = scanning_q;
  assign timeout_err_o    = timeout_err_q;

endmodule

// File: tb/tb_image_scan_controller.sv
// Self-checking bench for image_scan_controller. A behavioural stand-in for
// image_transmit_fsm answers each start pulse with randomized busy/mem_clear
// timing; expected start times and frame_done come from the frame-level rules
// (next start = effective clear + holdoff + 2, done = last clear + 1).
module tb_image_scan_controller;
  import image_pkg::*;

  localparam int Hold = 16;
  localparam int Tmo  = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] received_data = 8'd0;
  logic       new_received_data = 1'b0;
  logic       busy = 1'b0;
  logic       mem_clear = 1'b0;
  logic       start_transmit;
  logic [5:0] line_idx;
  logic       scanning;
  logic       frame_done;
  logic       timeout_err;

  image_scan_controller dut (
    .clk                 (clk),
    .rst                 (rst),
    .received_data_i     (received_data),
    .new_received_data_i (new_received_data),
    .busy_i              (busy),
    .mem_clear_i         (mem_clear),
    .start_transmit_o    (start_transmit),
    .line_idx_o          (line_idx),
    .scanning_o          (scanning),
    .frame_done_o        (frame_done),
    .timeout_err_o       (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Event log and reference timing
  int st_cyc[$];
  int st_line[$];
  int eff_q[$];   // effective clear time of each started line
  int fd_cnt = 0;
  int fd_cyc = -1;
  int s_cyc  = 0;

  // Transmit-FSM stand-in schedule
  int          on_at = -1, off_at = -1, clr_at = -1;
  bit          stuck = 1'b0;
  bit          fixed_tm = 1'b0;
  bit          prev_start = 1'b0;
  logic [63:0] early_mask = '0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled on the falling edge
  task automatic tick();
    int bd, bl, d;
    @(negedge clk);
    cyc++;
    new_received_data = 1'b0;
    if (start_transmit) begin
      check("no_back_to_back_start", int'(prev_start), 0);
      st_cyc.push_back(cyc);
      st_line.push_back(int'(line_idx));
      if (!stuck) begin
        if (fixed_tm) begin
          bd = 2; bl = 50; d = 20;
        end else begin
          bd = int'($urandom_range(1, 4));
          bl = int'($urandom_range(3, 20));
          d  = int'($urandom_range(1, 12));
        end
        on_at  = cyc + bd;
        off_at = on_at + bl;
        clr_at = early_mask[line_idx] ? on_at + 1 : off_at + d;
        // A clear before busy drops is remembered; the line completes as soon
        // as WAIT_CLEAR is entered, one clock after busy falls.
        eff_q.push_back((clr_at > off_at) ? clr_at : off_at + 1);
      end
    end
    prev_start = start_transmit;
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    busy      = (cyc >= on_at) && (cyc < off_at);
    mem_clear = (cyc == clr_at);
  endtask

  task automatic send_byte(input logic [7:0] b);
    received_data     = b;
    new_received_data = 1'b1;
    tick();
  endtask

  task automatic set_len(input logic [7:0] n);
    send_byte(CMD_LEN);
    send_byte(n);
  endtask

  task automatic frame_start();
    st_cyc.delete();
    st_line.delete();
    eff_q.delete();
    fd_cnt = 0;
    s_cyc  = cyc;
    send_byte(CMD_START);
    check("timeout_err_cleared_by_start", int'(timeout_err), 0);
  endtask

  task automatic frame_finish(input int n);
    int guard = 0;
    while (fd_cnt == 0 && guard < 150 * n + 200) begin
      tick();
      guard++;
    end
    check("frame_done_seen", fd_cnt, 1);
    check("num_starts", st_cyc.size(), n);
    check("num_lines_serviced", eff_q.size(), n);
    for (int i = 0; i < st_cyc.size() && i < n; i++) begin
      check("start_line_idx", st_line[i], i);
      if (i == 0) check("first_start_time", st_cyc[0], s_cyc + 1);
      else        check("start_gap_after_clear", st_cyc[i], eff_q[i-1] + Hold + 2);
    end
    if (eff_q.size() >= n) check("frame_done_time", fd_cyc, eff_q[n-1] + 1);
    tick();
    tick();
    check("scanning_low_after_frame", int'(scanning), 0);
    check("single_frame_done", fd_cnt, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_start"},    int'(start_transmit), 0);
    check({tag, "_line_idx"}, int'(line_idx), 0);
    check({tag, "_scanning"}, int'(scanning), 0);
    check({tag, "_done"},     int'(frame_done), 0);
    check({tag, "_timeout"},  int'(timeout_err), 0);
  endtask

  initial begin
    int guard;
    int t_to;
    int n;
    bit hit;

    repeat (2) tick();
    check_outputs_zero("reset");
    rst = 1'b1;
    tick();

    // Three-line frame with the fixed transmit timing
    fixed_tm = 1'b1;
    set_len(8'd3);
    frame_start();
    frame_finish(3);

    // Early mem_clear during busy on line 0
    early_mask = 64'h1;
    set_len(8'd2);
    frame_start();
    frame_finish(2);
    early_mask = '0;
    fixed_tm   = 1'b0;

    // Randomized frames
    for (int k = 0; k < 4; k++) begin
      n = int'($urandom_range(1, 6));
      early_mask = {$urandom, $urandom};
      set_len(8'(n));
      frame_start();
      frame_finish(n);
    end
    early_mask = '0;

    // Abort during holdoff after line 1
    set_len(8'd3);
    frame_start();
    guard = 0;
    hit = 1'b0;
    while (!hit && guard < 1000) begin
      tick();
      guard++;
      if (eff_q.size() >= 2 && cyc == eff_q[1] + 5) hit = 1'b1;
    end
    check("abort_point_reached", int'(hit), 1);
    send_byte(CMD_ABORT);
    check("abort_scanning", int'(scanning), 0);
    check("abort_line_idx", int'(line_idx), 0);
    check("abort_start", int'(start_transmit), 0);
    repeat (60) tick();
    check("abort_no_more_starts", st_cyc.size(), 2);
    check("abort_no_frame_done", fd_cnt, 0);

    // Watchdog: transmit side never raises busy
    stuck = 1'b1;
    frame_start();
    guard = 0;
    while (!timeout_err && guard < Tmo + 500) begin
      tick();
      guard++;
    end
    t_to = cyc;
    check("timeout_set", int'(timeout_err), 1);
    check("timeout_time", t_to, s_cyc + 2 + Tmo);
    check("timeout_idle", int'(scanning), 0);
    check("timeout_no_frame_done", fd_cnt, 0);
    check("timeout_one_start", st_cyc.size(), 1);
    stuck = 1'b0;
    frame_start();
    frame_finish(3);

    // Operand byte equal to 'S' must not start a frame; 0x53 clamps to 64
    set_len(CMD_START);
    st_cyc.delete();
    repeat (10) tick();
    check("operand_not_start", st_cyc.size(), 0);
    check("operand_not_scanning", int'(scanning), 0);
    frame_start();
    frame_finish(64);

    set_len(8'd5);
    set_len(8'd0);
    frame_start();
    frame_finish(64);

    set_len(8'd5);
    set_len(8'h50);
    frame_start();
    frame_finish(64);

    // Length write while scanning is discarded
    set_len(8'd3);
    frame_start();
    repeat (10) tick();
    set_len(8'd2);
    frame_finish(3);

    // Asynchronous reset while line 1 is in WAIT_TX
    frame_start();
    guard = 0;
    while (!(st_cyc.size() == 2 && busy && cyc >= on_at + 2) && guard < 1000) begin
      tick();
      guard++;
    end
    check("reset_point_line_idx", int'(line_idx), 1);
    #2 rst = 1'b0;
    #1 check_outputs_zero("async_reset");
    on_at = -1; off_at = -1; clr_at = -1;
    busy = 1'b0;
    mem_clear = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    frame_start();
    frame_finish(8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_time_limit: got cycle %0d expected finish before limit", cyc);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/image_scan_controller.md
Name: image_scan_controller

Overview:
- Sequences `image_transmit_fsm` through a full B-mode frame of N scan lines.
- Per line it issues one `start_transmit` pulse, tracks `busy` through transmit and receive, then waits for `mem_clear`. `mem_clear` marks that the host has drained line memory.
- After `mem_clear` it enforces a pulse-repetition holdoff and moves to the next line.
- Frame start, abort and line count come from host UART command bytes, on the same `received_data`/`new_received_data` strobe that feeds the transmit FSM.

Parameters:
- MAX_LINES, 64, upper bound on lines per frame.
- LINE_W, 6, width of line index (clog2 MAX_LINES).
- DEFAULT_LINES, 8, line count after reset.
- HOLDOFF_CYCLES, 16, idle clocks between `mem_clear` and the next `start_transmit` (PRF limit).
- TIMEOUT_CYCLES, 4096, watchdog limit per wait state.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset. The clock is `clk` and the reset is `rst`, exactly as the rest of the codebase names them. Reset is asynchronous and active-low; this is fixed.
- received_data  in  8  host command byte.
- new_received_data  in  1  one-cycle strobe qualifying `received_data`.
- busy  in  1  from `image_transmit_fsm`; high from transmit start until line capture completes.
- mem_clear  in  1  one-cycle pulse; host has drained line memory.
- start_transmit  out  1  one-cycle pulse to `image_transmit_fsm`.
- line_idx  out  LINE_W  current scan line, 0-based.
- scanning  out  1  high whenever the FSM is not in IDLE.
- frame_done  out  1  one-cycle pulse after the last line's `mem_clear`.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset values: all outputs 0; `num_lines` = DEFAULT_LINES; parser expecting an opcode; FSM in IDLE; watchdog 0.
- Command bytes:
  - 0x53 'S' = start frame. Honoured only in IDLE; it also clears `timeout_err`.
  - 0x41 'A' = abort. Honoured in any state.
  - 0x4C 'L' = set length. The next strobed byte is the line count and is always consumed as the operand, never as an opcode.
  - Count 0 or greater than MAX_LINES clamps to MAX_LINES.
  - Count is written only when not scanning; otherwise it is discarded.
  - All other bytes are ignored.
- FSM states: IDLE, START, WAIT_ACK, WAIT_TX, WAIT_CLEAR, HOLDOFF, DONE.
  - IDLE -> START on a valid 'S'. `line_idx` = 0.
  - START: `start_transmit` = 1 for exactly one cycle, then WAIT_ACK. The sticky `clear_seen` flag is cleared here.
  - WAIT_ACK -> WAIT_TX when `busy` = 1.
  - WAIT_TX -> WAIT_CLEAR when `busy` = 0.
  - WAIT_CLEAR: advances when `mem_clear` = 1 or `clear_seen` = 1.
    - If `line_idx` = `num_lines`-1 -> DONE.
    - Otherwise -> HOLDOFF.
  - HOLDOFF: counts HOLDOFF_CYCLES clocks, then increments `line_idx` and goes to START.
  - DONE: `frame_done` = 1 for one cycle, then IDLE. `line_idx` holds its last value until the next 'S'.
- Latency: `mem_clear` on cycle t gives the next `start_transmit` on cycle t+HOLDOFF_CYCLES+2.
- Early `mem_clear`: if `mem_clear` pulses in WAIT_ACK or WAIT_TX, it sets `clear_seen` and the pulse is not lost.
- Watchdog:
  - The counter resets on every state entry and counts only in WAIT_ACK, WAIT_TX and WAIT_CLEAR.
  - Reaching TIMEOUT_CYCLES sets `timeout_err`, forces IDLE and does not pulse `frame_done`.
- Abort: next cycle goes to IDLE with `start_transmit` = 0, `line_idx` = 0, `scanning` = 0, no `frame_done`. Abort takes priority over any same-cycle transition.
- Reset mid-frame: immediate return to reset values. `num_lines` reverts to DEFAULT_LINES.
- `scanning` is registered.
- `start_transmit` is never asserted on two consecutive cycles.

Decomposition:
- Package `image_pkg`:
  - Command opcode constants (CMD_START, CMD_ABORT, CMD_LEN).
  - Scan state enumeration, shared with debug LEDs/UART status.
- One sub-module, `scan_cmd_parser`:
  - Opcode/operand byte decoder.
  - Outputs `start_req`, `abort_req`, `len_wr`, `len_val`.
  - Keeps the FSM free of byte protocol.

Test Plan:
- Reset, 'L' then 0x03, then 'S'; the model raises `busy` 2 cycles after each `start_transmit`, drops it 50 cycles later, and pulses `mem_clear` 20 cycles after that.
  - Required: exactly 3 `start_transmit` pulses with `line_idx` 0,1,2.
  - Required: start-to-start gap of 16+2 clocks after each `mem_clear`.
  - Required: one `frame_done` after the third `mem_clear`; `scanning` low afterwards.
- `mem_clear` pulsed while `busy` = 1 on line 0 of a 2-line frame -> controller goes through WAIT_CLEAR without waiting and starts line 1 after the holdoff.
- 'A' during HOLDOFF of line 1 -> next cycle `scanning` = 0 and `line_idx` = 0; no further `start_transmit`; no `frame_done`.
- 'S' with `busy` held at 0 (model stuck) -> after 4096 clocks, `timeout_err` = 1 and state is IDLE.
  - A following 'S' clears `timeout_err` and starts line 0.
- 'L' then 0x00, and separately 'L' then 0x50 -> `num_lines` = 64 in both cases.
  - 'L' then 0x02 sent while scanning is discarded: the frame keeps its old count.
  - The operand byte 0x53 after 'L' does not start a frame.
- Assert `rst` low mid-WAIT_TX -> all outputs 0 asynchronously; `num_lines` = 8; a new 'S' runs 8 lines.
